mod_fetch_sequencer: RTL and testbench
======================================

Name: mod_fetch_sequencer

Overview:
Sequences the instruction ROM. It owns the program counter, drives the ROM word address and captures the returned instruction into a one-entry output register. The register hands instructions to decode over a valid/ready handshake. Also handles start, halt-on-mem_end, PC redirect (branch/jump) with flush, and a saturating fetch counter for debug.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into PC on reset and on start; bits [1:0] ignored.
CNT_WIDTH, 16, width of the fetch_count debug counter.

Ports:
clk  input  1  single system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  pulse; begins fetching from RESET_PC (accepted in IDLE and HALT only).
rom_address  output  30  word address to ROM; equals pc[31:2], combinational from PC register.
rom_instruction  input  32  ROM read data; combinational, valid in the same cycle as rom_address.
rom_mem_end  input  1  ROM flag; 1 when rom_address is past the last program word.
redirect_valid  input  1  branch/jump taken this cycle.
redirect_target  input  32  new byte PC; bits [1:0] forced to 0.
instr_valid  output  1  instr_out/instr_pc hold a valid instruction.
instr_ready  input  1  decode accepts the instruction this cycle.
instr_out  output  32  fetched instruction.
instr_pc  output  32  byte PC of instr_out.
halted  output  1  1 in HALT state.
fetch_count  output  CNT_WIDTH  count of instructions loaded since reset/start; saturates at all-ones.

Behaviour:
- States: IDLE, RUN, DRAIN, HALT. Encodings are 2-bit constants: IDLE=0, RUN=1, DRAIN=2, HALT=3.
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC&~3, instr_valid=0, instr_out=0, instr_pc=0, halted=0, fetch_count=0. Takes effect immediately, including mid-run; no pending instruction survives.
- Slot free: free = !instr_valid | instr_ready.
- IDLE: start=1 -> pc=RESET_PC&~3, fetch_count=0, state=RUN. redirect is ignored.
- RUN, priority order:
  1. redirect_valid: pc=redirect_target&~3, instr_valid=0 (flush, even if instr_ready=1 that cycle), no load, stay RUN.
  2. free & !rom_mem_end: instr_out=rom_instruction, instr_pc=pc, instr_valid=1, pc=pc+4 (wraps mod 2^32), fetch_count++ (saturating).
  3. free & rom_mem_end: instr_valid=0, state=HALT.
  4. !free: hold all outputs and pc (stall).
- Entering DRAIN: in RUN, when !free & rom_mem_end, state=DRAIN.
- DRAIN:
  - redirect_valid -> same as RUN rule 1, state=RUN.
  - Otherwise, on instr_ready -> instr_valid=0, state=HALT.
- HALT: halted=1, instr_valid=0. start -> behaves as in IDLE (pc reload, counter clear, RUN). redirect is ignored.
- start in RUN/DRAIN is ignored.
- Latency: start sampled at edge N -> RUN after N. First instr_valid=1 after edge N+1 (PC=RESET_PC). Throughput is 1 instr/cycle while instr_ready=1.
- Redirect latency: target instruction is valid 1 cycle after the redirect edge.
- instr_out/instr_pc are stable while instr_valid=1 & instr_ready=0.
- fetch_count at all-ones stays all-ones.

Decomposition:
- Shared header fetch_defs.vh: state encodings and the PC increment constant (4).
- One sub-module: mod_fetch_out_reg. It is the valid/ready holding register (load, flush, hold), with ports load, flush, d_instr, d_pc, ready; it outputs valid, instr, pc.
- FSM, PC and counter stay in the top.

Test Plan:
- Bench ROM model: words 0..2 = 0x20050005, 0x20060001, 0x00A62022; mem_end = (address>2).
- Straight run: reset, start pulse, instr_ready=1.
  - Required: 0x20050005@pc0, 0x20060001@pc4, 0x00A62022@pc8 on consecutive cycles.
  - Then halted=1, instr_valid=0, fetch_count=3.
- Backpressure: instr_ready=0 for 3 cycles after the first valid.
  - Required: instr_out stays 0x20050005 and rom_address stays 1.
  - On release, the remaining two instructions are delivered in order.
- Drain: instr_ready=0 while pc=12.
  - Required: state DRAIN, instr_out=0x00A62022 held; halted=1 one cycle after instr_ready=1.
- Redirect: redirect_valid=1, target=0x00000006 while 0x20060001 is pending.
  - Required: instr_valid=0 next cycle, then 0x00A62022@pc4? No: target masks to 0x4, so the required output is 0x20060001@pc4.
  - fetch_count reflects only the loads.
- Reset mid-run: drop rst_n asynchronously during RUN with instr_valid=1.
  - Required: outputs clear immediately, state IDLE, rom_address=0.
- Restart from HALT: start -> fetch_count=0, then 0x20050005@pc0 again.

Source files
------------

// File: rtl/mod_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encodings and PC step.
package mod_fetch_sequencer_pkg;

  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned WORD_WIDTH  = 32;
  localparam int unsigned ROM_AWIDTH  = 30;

  localparam logic [ADDR_WIDTH-1:0] PC_INCR    = 32'd4;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~32'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // Word-align a byte address.
  function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/mod_fetch_out_reg.sv
// One-entry valid/ready holding register between fetch and decode.
module mod_fetch_out_reg
  import mod_fetch_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  flush,
  input  logic [WORD_WIDTH-1:0] d_instr,
  input  logic [ADDR_WIDTH-1:0] d_pc,
  input  logic                  ready,
  output logic                  valid,
  output logic [WORD_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] pc
);

  // Flush beats load; an accepted entry empties unless refilled the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= d_instr;
      pc    <= d_pc;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mod_fetch_sequencer.sv
// Instruction ROM sequencer: owns the PC, fetches into a one-entry output register.
module mod_fetch_sequencer
  import mod_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0]  RESET_PC  = 32'h0000_0000,
  parameter int unsigned  CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [29:0]           rom_address,
  input  logic [31:0]           rom_instruction,
  input  logic                  rom_mem_end,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_target,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr_out,
  output logic [31:0]           instr_pc,
  output logic                  halted,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  localparam logic [ADDR_WIDTH-1:0] RESET_PC_ALIGNED = RESET_PC & ALIGN_MASK;

  fetch_state_e          state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  slot_free;
  logic                  load;
  logic                  flush;

  assign rom_address = pc[31:2];
  assign slot_free   = !instr_valid || instr_ready;
  assign flush       = redirect_valid && (state == ST_RUN || state == ST_DRAIN);
  assign load        = (state == ST_RUN) && !redirect_valid && slot_free && !rom_mem_end;

  // FSM, PC and saturating fetch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc          <= RESET_PC_ALIGNED;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state       <= ST_RUN;
            pc          <= RESET_PC_ALIGNED;
            fetch_count <= '0;
            halted      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (redirect_valid) begin
            pc <= align_pc(redirect_target);
          end else if (slot_free) begin
            if (!rom_mem_end) begin
              pc <= pc + PC_INCR;
              if (fetch_count != '1) fetch_count <= fetch_count + CNT_WIDTH'(1);
            end else begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end
          end else if (rom_mem_end) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (redirect_valid) begin
            pc    <= align_pc(redirect_target);
            state <= ST_RUN;
          end else if (instr_ready) begin
            state  <= ST_HALT;
            halted <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mod_fetch_out_reg u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .flush   (flush),
    .d_instr (rom_instruction),
    .d_pc    (pc),
    .ready   (instr_ready),
    .valid   (instr_valid),
    .instr   (instr_out),
    .pc      (instr_pc)
  );

endmodule

// File: tb/tb_mod_fetch_sequencer.sv
// Directed bench for mod_fetch_sequencer against a three-word ROM.
module tb_mod_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [29:0] rom_address;
  logic [31:0] rom_instruction;
  logic        rom_mem_end;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        halted;
  logic [15:0] fetch_count;

  int n_checks = 0;
  int n_fails  = 0;

  mod_fetch_sequencer #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .rom_address     (rom_address),
    .rom_instruction (rom_instruction),
    .rom_mem_end     (rom_mem_end),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_out       (instr_out),
    .instr_pc        (instr_pc),
    .halted          (halted),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model
  always_comb begin
    case (rom_address)
      30'd0:   rom_instruction = 32'h2005_0005;
      30'd1:   rom_instruction = 32'h2006_0001;
      30'd2:   rom_instruction = 32'h00A6_2022;
      default: rom_instruction = 32'h0000_0000;
    endcase
    rom_mem_end = (rom_address > 30'd2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid: got %b need 0", instr_valid); end
    n_checks++; if (instr_out !== 32'h0) begin n_fails++; $display("FAIL reset_instr: got %h need 0", instr_out); end
    n_checks++; if (halted !== 1'b0 || fetch_count !== 16'd0) begin n_fails++; $display("FAIL reset_halt_cnt: got %b/%0d need 0/0", halted, fetch_count); end
    n_checks++; if (rom_address !== 30'd0 || dut.state !== 2'd0) begin n_fails++; $display("FAIL reset_addr_state: got %0d/%0d need 0/0", rom_address, dut.state); end
    rst_n = 1'b1;
    // redirect in IDLE is ignored
    redirect_valid = 1'b1; redirect_target = 32'h8;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (rom_address !== 30'd0 || dut.state !== 2'd0) begin n_fails++; $display("FAIL idle_redirect: got addr %0d state %0d need 0/0", rom_address, dut.state); end
  endtask

  task automatic test_straight_run();
    instr_ready = 1'b1;
    pulse_start();
    n_checks++; if (dut.state !== 2'd1 || instr_valid !== 1'b0) begin n_fails++; $display("FAIL run_enter: got state %0d valid %b need 1/0", dut.state, instr_valid); end
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h2005_0005 || instr_pc !== 32'h0) begin n_fails++; $display("FAIL run_i0: got %b %h@%h need 1 20050005@0", instr_valid, instr_out, instr_pc); end
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h2006_0001 || instr_pc !== 32'h4) begin n_fails++; $display("FAIL run_i1: got %b %h@%h need 1 20060001@4", instr_valid, instr_out, instr_pc); end
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h00A6_2022 || instr_pc !== 32'h8) begin n_fails++; $display("FAIL run_i2: got %b %h@%h need 1 00a62022@8", instr_valid, instr_out, instr_pc); end
    tick();
    n_checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || fetch_count !== 16'd3) begin n_fails++; $display("FAIL run_halt: got halted %b valid %b cnt %0d need 1/0/3", halted, instr_valid, fetch_count); end
    // redirect in HALT is ignored
    redirect_valid = 1'b1; redirect_target = 32'h4;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (halted !== 1'b1 || rom_address !== 30'd3) begin n_fails++; $display("FAIL halt_redirect: got halted %b addr %0d need 1/3", halted, rom_address); end
  endtask

  task automatic test_backpressure();
    instr_ready = 1'b0;
    pulse_start();
    n_checks++; if (fetch_count !== 16'd0 || halted !== 1'b0) begin n_fails++; $display("FAIL bp_restart: got cnt %0d halted %b need 0/0", fetch_count, halted); end
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h2005_0005 || rom_address !== 30'd1) begin n_fails++; $display("FAIL bp_hold%0d: got %b %h addr %0d need 1 20050005 addr 1", i, instr_valid, instr_out, rom_address); end
      tick();
    end
    instr_ready = 1'b1;
    tick();
    n_checks++; if (instr_out !== 32'h2006_0001 || instr_pc !== 32'h4) begin n_fails++; $display("FAIL bp_i1: got %h@%h need 20060001@4", instr_out, instr_pc); end
    tick();
    n_checks++; if (instr_out !== 32'h00A6_2022 || instr_pc !== 32'h8) begin n_fails++; $display("FAIL bp_i2: got %h@%h need 00a62022@8", instr_out, instr_pc); end
    tick();
    n_checks++; if (halted !== 1'b1 || fetch_count !== 16'd3) begin n_fails++; $display("FAIL bp_end: got halted %b cnt %0d need 1/3", halted, fetch_count); end
  endtask

  task automatic test_drain();
    instr_ready = 1'b1;
    pulse_start();
    tick(); tick(); tick();
    instr_ready = 1'b0;
    tick();
    n_checks++; if (dut.state !== 2'd2 || instr_out !== 32'h00A6_2022 || instr_valid !== 1'b1 || halted !== 1'b0) begin n_fails++; $display("FAIL drain_enter: got state %0d %h valid %b halted %b need 2 00a62022 1 0", dut.state, instr_out, instr_valid, halted); end
    tick();
    n_checks++; if (dut.state !== 2'd2 || instr_out !== 32'h00A6_2022) begin n_fails++; $display("FAIL drain_hold: got state %0d %h need 2 00a62022", dut.state, instr_out); end
    instr_ready = 1'b1;
    tick();
    n_checks++; if (halted !== 1'b1 || instr_valid !== 1'b0) begin n_fails++; $display("FAIL drain_halt: got halted %b valid %b need 1/0", halted, instr_valid); end
  endtask

  task automatic test_redirect();
    instr_ready = 1'b1;
    pulse_start();
    tick(); tick();
    n_checks++; if (instr_out !== 32'h2006_0001 || instr_pc !== 32'h4) begin n_fails++; $display("FAIL rd_pending: got %h@%h need 20060001@4", instr_out, instr_pc); end
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0000_0006;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (instr_valid !== 1'b0 || rom_address !== 30'd1 || fetch_count !== 16'd2) begin n_fails++; $display("FAIL rd_flush: got valid %b addr %0d cnt %0d need 0/1/2", instr_valid, rom_address, fetch_count); end
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h2006_0001 || instr_pc !== 32'h4 || fetch_count !== 16'd3) begin n_fails++; $display("FAIL rd_target: got %b %h@%h cnt %0d need 1 20060001@4 cnt 3", instr_valid, instr_out, instr_pc, fetch_count); end
    instr_ready = 1'b1;
    tick(); tick();
    n_checks++; if (halted !== 1'b1 || fetch_count !== 16'd4) begin n_fails++; $display("FAIL rd_end: got halted %b cnt %0d need 1/4", halted, fetch_count); end
  endtask

  task automatic test_reset_mid_run();
    instr_ready = 1'b0;
    pulse_start();
    tick();
    n_checks++; if (instr_valid !== 1'b1) begin n_fails++; $display("FAIL mr_pre: got valid %b need 1", instr_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (instr_valid !== 1'b0 || instr_out !== 32'h0 || instr_pc !== 32'h0) begin n_fails++; $display("FAIL mr_outputs: got %b %h@%h need 0 0@0", instr_valid, instr_out, instr_pc); end
    n_checks++; if (dut.state !== 2'd0 || rom_address !== 30'd0 || fetch_count !== 16'd0) begin n_fails++; $display("FAIL mr_state: got state %0d addr %0d cnt %0d need 0/0/0", dut.state, rom_address, fetch_count); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_restart_from_halt();
    instr_ready = 1'b1;
    pulse_start();
    tick(); tick(); tick(); tick();
    n_checks++; if (halted !== 1'b1 || fetch_count !== 16'd3) begin n_fails++; $display("FAIL rs_halt: got halted %b cnt %0d need 1/3", halted, fetch_count); end
    pulse_start();
    n_checks++; if (fetch_count !== 16'd0 || halted !== 1'b0 || dut.state !== 2'd1) begin n_fails++; $display("FAIL rs_start: got cnt %0d halted %b state %0d need 0/0/1", fetch_count, halted, dut.state); end
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_out !== 32'h2005_0005 || instr_pc !== 32'h0) begin n_fails++; $display("FAIL rs_i0: got %b %h@%h need 1 20050005@0", instr_valid, instr_out, instr_pc); end
  endtask

  initial begin
    test_reset();
    test_straight_run();
    test_backpressure();
    test_drain();
    test_redirect();
    test_reset_mid_run();
    test_restart_from_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
